// File: rtl/fifo_buffer_ctrl.sv
// Parametrised synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and
// a selectable registered or first-word-fall-through read port.
// Full/empty derive only from the occupancy count, so equal read and write
// pointers are never ambiguous.
module fifo_buffer_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [DATA_W-1:0] wdata,
  input  logic              read,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LEVEL);

  // Threshold legality is checked once at elaboration.
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_buffer_ctrl: AF_LEVEL %0d outside 1..%0d", AF_LEVEL, DEPTH);
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_buffer_ctrl: AE_LEVEL %0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count_q;
  logic              wr_acc;
  logic              rd_acc;

  // Status flags are pure functions of the registered occupancy.
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  // A blocked request never affects the other one: full blocks only the
  // write, empty blocks only the read.
  assign wr_acc = write & ~full;
  assign rd_acc = read & ~empty;

  // Storage array: written on accepted writes only.
  // NOTE: the memory deliberately has no reset; clearing it would force a
  // flop-based array and the pointers/count already make old data invisible.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers and occupancy count; reset overrides every other input.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      count_q <= count_q + (ADDR_W + 1)'(wr_acc) - (ADDR_W + 1)'(rd_acc);
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~clr_err) | (write & full);
      underflow <= (underflow & ~clr_err) | (read  & empty);
    end
  end

  if (FWFT) begin : g_fwft
    // Head word is presented combinationally whenever the FIFO holds data.
    assign rdata  = mem[rptr];
    assign rvalid = ~empty;
  end else begin : g_reg_read
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    // Registered read: one-cycle data pulse per accepted read, data held otherwise.
    always_ff @(posedge clk) begin
      if (reset) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= mem[rptr];
      end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end

endmodule

// File: tb/tb_fifo_buffer_ctrl.sv
// Self-checking bench for fifo_buffer_ctrl: a registered-read instance is
// checked through a scoreboard queue popped by a monitor on rvalid, and a
// first-word-fall-through instance is checked with directed vectors.
module tb_fifo_buffer_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic clk;
  logic reset;

  // Registered-read instance
  logic              write0, read0, clr0;
  logic [DATA_W-1:0] wdata0, rdata0;
  logic              rvalid0, empty0, full0, af0, ae0, ovf0, udf0;
  logic [ADDR_W:0]   count0;

  // First-word-fall-through instance
  logic              write1, read1, clr1;
  logic [DATA_W-1:0] wdata1, rdata1;
  logic              rvalid1, empty1, full1, af1, ae1, ovf1, udf1;
  logic [ADDR_W:0]   count1;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] model_q [$];  // words the bench believes are stored
  logic [DATA_W-1:0] exp_q   [$];  // expected registered-read outputs

  fifo_buffer_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1'b0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .write(write0), .wdata(wdata0), .read(read0),
    .clr_err(clr0), .rdata(rdata0), .rvalid(rvalid0), .empty(empty0),
    .full(full0), .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(udf0)
  );

  fifo_buffer_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(1'b1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .write(write1), .wdata(wdata1), .read(read1),
    .clr_err(clr1), .rdata(rdata1), .rvalid(rvalid1), .empty(empty1),
    .full(full1), .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(udf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle on the registered-read instance and record what a
  // correct FIFO would return for any accepted read.
  task automatic drive(input logic w, input logic [DATA_W-1:0] d,
                       input logic r, input logic c);
    logic wr_ok, rd_ok;
    write0 = w;
    wdata0 = d;
    read0  = r;
    clr0   = c;
    wr_ok = w && (model_q.size() < DEPTH);
    rd_ok = r && (model_q.size() > 0);
    if (rd_ok) exp_q.push_back(model_q.pop_front());
    if (wr_ok) model_q.push_back(d);
    step();
  endtask

  // Monitor: every rvalid pulse must match the next expected word.
  always @(negedge clk) begin
    if (!reset && rvalid0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 32'(rvalid0), 32'd0);
      end else begin
        check("rdata_order", rdata0, exp_q.pop_front());
      end
    end
  end

  initial begin
    write0 = 0; read0 = 0; clr0 = 0; wdata0 = '0;
    write1 = 0; read1 = 0; clr1 = 0; wdata1 = '0;
    reset  = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_count", 32'(count0), 32'd0);
    check("rst_empty", 32'(empty0), 32'd1);
    check("rst_full",  32'(full0),  32'd0);
    check("rst_ae",    32'(ae0),    32'd1);
    check("rst_af",    32'(af0),    32'd0);
    check("rst_ovf",   32'(ovf0),   32'd0);
    check("rst_udf",   32'(udf0),   32'd0);
    check("rst_rvalid", 32'(rvalid0), 32'd0);
    check("rst_rdata", rdata0, 32'd0);

    // Fill: 16 writes, flags follow the count thresholds
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
      check("fill_count", 32'(count0), 32'(i + 1));
      check("fill_ae",    32'(ae0),    32'((i + 1) <= 2));
      check("fill_af",    32'(af0),    32'((i + 1) >= 12));
      check("fill_full",  32'(full0),  32'((i + 1) == 16));
      check("fill_ovf",   32'(ovf0),   32'd0);
    end

    // Write while full is dropped and sets overflow
    drive(1'b1, 32'hDEAD, 1'b0, 1'b0);
    check("ovf_count", 32'(count0), 32'd16);
    check("ovf_flag",  32'(ovf0),   32'd1);

    // Drain: each read yields rvalid one cycle later, data checked by monitor
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check("drain_rvalid", 32'(rvalid0), 32'd1);
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    check("drain_rvalid_drop", 32'(rvalid0), 32'd0);
    check("drain_empty", 32'(empty0), 32'd1);
    check("drain_count", 32'(count0), 32'd0);

    // Read+write on empty: write accepted, underflow sets, no read data
    drive(1'b1, 32'h55, 1'b1, 1'b0);
    check("udf_count",  32'(count0),  32'd1);
    check("udf_flag",   32'(udf0),    32'd1);
    check("udf_rvalid", 32'(rvalid0), 32'd0);

    // clr_err alone clears both sticky flags
    drive(1'b0, '0, 1'b0, 1'b1);
    check("clr_ovf", 32'(ovf0), 32'd0);
    check("clr_udf", 32'(udf0), 32'd0);

    // Bring occupancy to 8, then 20 cycles of simultaneous read/write
    for (int i = 0; i < 7; i++) drive(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    check("mid_count", 32'(count0), 32'd8);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h300 + 32'(i), 1'b1, 1'b0);
      check("rw_count", 32'(count0), 32'd8);
      check("rw_flags", {28'd0, full0, empty0, af0, ae0}, 32'd0);
    end
    for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("rw_drain_empty", 32'(empty0), 32'd1);

    // First-word-fall-through instance
    check("fwft_rst_rvalid", 32'(rvalid1), 32'd0);
    write1 = 1'b1; wdata1 = 32'hA1;
    step();
    check("fwft_first_rvalid", 32'(rvalid1), 32'd1);
    check("fwft_first_rdata",  rdata1,       32'hA1);
    wdata1 = 32'hA2;
    step();
    write1 = 1'b0;
    read1  = 1'b1;
    step();
    check("fwft_pop_rdata",  rdata1,       32'hA2);
    check("fwft_pop_rvalid", 32'(rvalid1), 32'd1);
    step();
    read1 = 1'b0;
    check("fwft_end_empty",  32'(empty1),  32'd1);
    check("fwft_end_rvalid", 32'(rvalid1), 32'd0);

    // Reset mid-operation overrides a concurrent write
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
    check("pre_rst_count", 32'(count0), 32'd5);
    reset  = 1'b1;
    write0 = 1'b1;
    wdata0 = 32'h77;
    step();
    model_q.delete();
    reset  = 1'b0;
    write0 = 1'b0;
    check("mrst_count", 32'(count0), 32'd0);
    check("mrst_empty", 32'(empty0), 32'd1);
    check("mrst_ovf",   32'(ovf0),   32'd0);
    check("mrst_udf",   32'(udf0),   32'd0);
    step();
    check("mrst_count_hold", 32'(count0), 32'd0);
    check("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
